// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, read-select map and width helpers for the float statistics monitor
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO   = 3'd0,
    FP_DENORM = 3'd1,
    FP_NORMAL = 3'd2,
    FP_INF    = 3'd3,
    FP_NAN    = 3'd4,
    FP_NONE   = 3'd7
  } fp_class_e;

  localparam logic [2:0] RD_ZERO   = 3'd0;
  localparam logic [2:0] RD_DENORM = 3'd1;
  localparam logic [2:0] RD_NORMAL = 3'd2;
  localparam logic [2:0] RD_INF    = 3'd3;
  localparam logic [2:0] RD_NAN    = 3'd4;
  localparam logic [2:0] RD_NEG    = 3'd5;
  localparam logic [2:0] RD_TOTAL  = 3'd6;
  localparam logic [2:0] RD_MAXEXP = 3'd7;

  localparam int NUM_CNT = 7;

  function automatic int fp_bias(input int exp_bits);
    return (1 << (exp_bits - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_bits, input int mant_bits);
    return 1 + exp_bits + mant_bits;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational decode of one float word into class, sign and raw exponent
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic [EXP_BITS+MANT_BITS:0] word,
  output fp_class_e                   cls,
  output logic                        sign,
  output logic [EXP_BITS-1:0]         exponent
);

  logic [MANT_BITS-1:0] mant;

  assign sign     = word[EXP_BITS+MANT_BITS];
  assign exponent = word[MANT_BITS +: EXP_BITS];
  assign mant     = word[MANT_BITS-1:0];

  always_comb begin
    cls = FP_NORMAL;
    if (exponent == '0) begin
      cls = (mant == '0) ? FP_ZERO : FP_DENORM;
    end else if (&exponent) begin
      cls = (mant == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_stat_monitor.sv
// rtl/fp_stat_monitor.sv - passive multi-lane float tap: per-lane classification and saturating statistics
module fp_stat_monitor
  import fp_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int LANES     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic [LANES*fp_width(EXP_BITS,MANT_BITS)-1:0] in_data,
  input  logic [LANES-1:0]                              in_mask,
  output logic                                          cls_valid,
  output logic [LANES*3-1:0]                            cls_code,
  input  logic                                          clear,
  input  logic                                          rd_req,
  input  logic [2:0]                                    rd_sel,
  output logic                                          rd_valid,
  output logic [CNT_W-1:0]                              rd_data
);

  localparam int W     = fp_width(EXP_BITS, MANT_BITS);
  localparam int INC_W = $clog2(LANES + 1);

  fp_class_e             lane_cls  [LANES];
  logic                  lane_sign [LANES];
  logic [EXP_BITS-1:0]   lane_exp  [LANES];

  fp_class_e             s1_cls    [LANES];
  logic                  s1_sign   [LANES];
  logic [EXP_BITS-1:0]   s1_exp    [LANES];
  logic                  s1_valid;

  logic [INC_W-1:0]      inc       [NUM_CNT];
  logic [CNT_W-1:0]      cnt       [NUM_CNT];
  logic [EXP_BITS-1:0]   max_exp;
  logic [EXP_BITS-1:0]   max_exp_next;
  logic [CNT_W-1:0]      rd_mux;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_classify #(
      .EXP_BITS (EXP_BITS),
      .MANT_BITS(MANT_BITS)
    ) u_classify (
      .word    (in_data[g*W +: W]),
      .cls     (lane_cls[g]),
      .sign    (lane_sign[g]),
      .exponent(lane_exp[g])
    );
    assign cls_code[g*3 +: 3] = s1_cls[g];
  end

  assign cls_valid = s1_valid;

  // Stage 1: masked or invalid lanes collapse to NONE so stage 2 never needs the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_cls[i]  <= FP_NONE;
        s1_sign[i] <= 1'b0;
        s1_exp[i]  <= '0;
      end
    end else begin
      s1_valid <= in_valid;
      for (int i = 0; i < LANES; i++) begin
        s1_cls[i]  <= (in_valid && in_mask[i]) ? lane_cls[i] : FP_NONE;
        s1_sign[i] <= lane_sign[i];
        s1_exp[i]  <= lane_exp[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) inc[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      case (s1_cls[i])
        FP_ZERO:   inc[RD_ZERO]   = inc[RD_ZERO]   + INC_W'(1);
        FP_DENORM: inc[RD_DENORM] = inc[RD_DENORM] + INC_W'(1);
        FP_NORMAL: inc[RD_NORMAL] = inc[RD_NORMAL] + INC_W'(1);
        FP_INF:    inc[RD_INF]    = inc[RD_INF]    + INC_W'(1);
        FP_NAN:    inc[RD_NAN]    = inc[RD_NAN]    + INC_W'(1);
        default: ;
      endcase
      if (s1_cls[i] != FP_NONE) inc[RD_TOTAL] = inc[RD_TOTAL] + INC_W'(1);
      if (s1_sign[i] && s1_cls[i] != FP_NAN && s1_cls[i] != FP_NONE)
        inc[RD_NEG] = inc[RD_NEG] + INC_W'(1);
    end
  end

  // INF/NAN carry an all-ones exponent that would pin MAXEXP, so only finite lanes compete.
  always_comb begin
    max_exp_next = max_exp;
    for (int i = 0; i < LANES; i++) begin
      if ((s1_cls[i] == FP_ZERO || s1_cls[i] == FP_DENORM || s1_cls[i] == FP_NORMAL) &&
          s1_exp[i] > max_exp_next)
        max_exp_next = s1_exp[i];
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < NUM_CNT; k++) cnt[k] <= '0;
      max_exp <= '0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) cnt[k] <= sat_add(cnt[k], inc[k]);
      max_exp <= max_exp_next;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      RD_ZERO:   rd_mux = cnt[RD_ZERO];
      RD_DENORM: rd_mux = cnt[RD_DENORM];
      RD_NORMAL: rd_mux = cnt[RD_NORMAL];
      RD_INF:    rd_mux = cnt[RD_INF];
      RD_NAN:    rd_mux = cnt[RD_NAN];
      RD_NEG:    rd_mux = cnt[RD_NEG];
      RD_TOTAL:  rd_mux = cnt[RD_TOTAL];
      RD_MAXEXP: rd_mux = CNT_W'(max_exp);
      default:   rd_mux = '0;
    endcase
  end

  // Sampling the counters before their update gives read-vs-update and read-vs-clear their old-value semantics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fp_stat_monitor.sv
// tb/tb_fp_stat_monitor.sv - self-checking bench for fp_stat_monitor (fp32 wide/narrow counters, fp16)
module tb_fp_stat_monitor;

  logic         clk = 1'b0;
  logic         rst, in_valid, clear, rd_req;
  logic [3:0]   in_mask;
  logic [2:0]   rd_sel;
  logic [127:0] in_data32;
  logic [63:0]  in_data16;

  logic         cv32, cv8, cv16, rv32, rv8, rv16;
  logic [11:0]  cc32, cc8, cc16;
  logic [31:0]  rd32, rd16;
  logic [7:0]   rd8;

  int checks = 0;
  int errors = 0;

  // model[cfg][stat]: cfg 0 = fp32/CNT_W 32, 1 = fp32/CNT_W 8, 2 = fp16/CNT_W 32; stat 7 = MAXEXP
  longint model [3][8];
  longint lim   [3] = '{64'hFFFF_FFFF, 255, 64'hFFFF_FFFF};
  int     eb    [3] = '{8, 8, 5};
  int     mb    [3] = '{23, 23, 10};
  logic [31:0] d32 [4];
  logic [31:0] d16 [4];

  always #5 clk = ~clk;

  fp_stat_monitor #(.EXP_BITS(8), .MANT_BITS(23), .LANES(4), .CNT_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data32), .in_mask(in_mask),
    .cls_valid(cv32), .cls_code(cc32), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv32), .rd_data(rd32));

  fp_stat_monitor #(.EXP_BITS(8), .MANT_BITS(23), .LANES(4), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data32), .in_mask(in_mask),
    .cls_valid(cv8), .cls_code(cc8), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv8), .rd_data(rd8));

  fp_stat_monitor #(.EXP_BITS(5), .MANT_BITS(10), .LANES(4), .CNT_W(32)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data16), .in_mask(in_mask),
    .cls_valid(cv16), .cls_code(cc16), .clear(clear), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv16), .rd_data(rd16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_of(input logic [31:0] w, input int e, input int m);
    return int'((w >> m) & ((32'd1 << e) - 1));
  endfunction

  function automatic int cls_of(input logic [31:0] w, input int e, input int m);
    int ex;
    logic [31:0] mt;
    ex = exp_of(w, e, m);
    mt = w & ((32'd1 << m) - 1);
    if (ex == 0) return (mt == 0) ? 0 : 1;
    if (ex == (1 << e) - 1) return (mt == 0) ? 3 : 4;
    return 2;
  endfunction

  function automatic logic [31:0] make_word(input int c, input int e, input int m);
    logic [31:0] s, ex, mt;
    int emax;
    emax = (1 << e) - 1;
    s  = 32'($urandom_range(0, 1));
    ex = 0;
    mt = 0;
    case (c)
      1: mt = 32'($urandom_range(1, (1 << m) - 1));
      2: begin ex = 32'($urandom_range(1, emax - 1)); mt = 32'($urandom_range(0, (1 << m) - 1)); end
      3: ex = 32'(emax);
      4: begin ex = 32'(emax); mt = 32'($urandom_range(1, (1 << m) - 1)); end
      default: ;
    endcase
    return (s << (e + m)) | (ex << m) | mt;
  endfunction

  task automatic bump(input int cfg, input int k);
    if (model[cfg][k] < lim[cfg]) model[cfg][k] = model[cfg][k] + 1;
  endtask

  task automatic model_lane(input int cfg, input logic [31:0] w);
    int c, ex;
    c  = cls_of(w, eb[cfg], mb[cfg]);
    ex = exp_of(w, eb[cfg], mb[cfg]);
    bump(cfg, c);
    bump(cfg, 6);
    if (((w >> (eb[cfg] + mb[cfg])) & 1) == 1 && c != 4) bump(cfg, 5);
    if (c <= 2 && ex > model[cfg][7]) model[cfg][7] = ex;
  endtask

  task automatic model_add(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        model_lane(0, d32[i]);
        model_lane(1, d32[i]);
        model_lane(2, d16[i]);
      end
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 8; k++) model[c][k] = 0;
  endtask

  task automatic drive_beat(input logic v, input logic [3:0] mask);
    logic [11:0] e32, e16;
    for (int i = 0; i < 4; i++) begin
      in_data32[i*32 +: 32] = d32[i];
      in_data16[i*16 +: 16] = d16[i][15:0];
      e32[i*3 +: 3] = (v && mask[i]) ? 3'(cls_of(d32[i], 8, 23)) : 3'd7;
      e16[i*3 +: 3] = (v && mask[i]) ? 3'(cls_of(d16[i], 5, 10)) : 3'd7;
    end
    in_valid = v;
    in_mask  = mask;
    tick();
    in_valid = 1'b0;
    chk("cls_valid", cv32, v);
    chk("cls_code32", cc32, e32);
    chk("cls_code16", cc16, e16);
  endtask

  task automatic read_one(input int s);
    rd_req = 1'b1;
    rd_sel = 3'(s);
    tick();
    chk($sformatf("rd_valid_sel%0d", s), rv32, 1);
    chk($sformatf("rd32_sel%0d", s), rd32, model[0][s]);
    chk($sformatf("rd8_sel%0d", s), rd8, model[1][s]);
    chk($sformatf("rd16_sel%0d", s), rd16, model[2][s]);
  endtask

  task automatic read_all();
    for (int s = 0; s < 8; s++) read_one(s);
    rd_req = 1'b0;
    tick();
    chk("rd_valid_drop", rv32, 0);
    chk("rd_data_hold", rd32, model[0][7]);
  endtask

  task automatic rand_beat();
    logic v;
    logic [3:0] mask;
    for (int i = 0; i < 4; i++) begin
      d32[i] = make_word($urandom_range(0, 4), 8, 23);
      d16[i] = make_word($urandom_range(0, 4), 5, 10);
    end
    v    = ($urandom_range(0, 3) != 0);
    mask = 4'($urandom_range(0, 15));
    drive_beat(v, mask);
    if (v) model_add(mask);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; rd_req = 1'b0; rd_sel = '0;
    in_mask = '0; in_data32 = '0; in_data16 = '0;
    model_clear();
    tick();
    tick();
    chk("rst_cls_valid", cv32, 0);
    chk("rst_cls_code", cc32, 12'hFFF);
    chk("rst_rd_valid", rv32, 0);
    chk("rst_rd_data", rd32, 0);
    rst = 1'b0;
    tick();
    read_all();

    // directed beat: one of each finite/infinite class
    d32 = '{32'h0000_0000, 32'h0000_0001, 32'h3F80_0000, 32'h7F80_0000};
    d16 = '{32'h7C00, 32'h7C01, 32'h0400, 32'h0000};
    drive_beat(1'b1, 4'hF);
    chk("beat1_code32", cc32, 12'h688);
    chk("beat1_code16", cc16, 12'h0A3);
    model_add(4'hF);
    tick();
    chk("beat1_cls_valid_drop", cv32, 0);
    read_all();
    chk("beat1_maxexp32", rd32, 32'h7F);
    chk("beat1_maxexp16", rd16, 32'h1);

    // directed beat: NaN excluded from NEG, masked lanes ignored
    d32 = '{32'hFFC0_0000, 32'h8000_0000, 32'hC000_0000, 32'h7FC0_0001};
    d16 = '{32'h8000, 32'h7C01, 32'hBC00, 32'h0001};
    drive_beat(1'b1, 4'b0101);
    chk("beat2_code32", cc32, 12'hEBC);
    model_add(4'b0101);
    tick();
    read_one(5);
    chk("beat2_neg32", rd32, 1);
    read_all();

    for (int n = 0; n < 40; n++) rand_beat();
    tick();
    read_all();

    // read in the same cycle as a TOTAL update returns the old value, then the new one
    for (int i = 0; i < 4; i++) begin
      d32[i] = make_word(2, 8, 23);
      d16[i] = make_word($urandom_range(0, 4), 5, 10);
    end
    drive_beat(1'b1, 4'hF);
    rd_req = 1'b1;
    rd_sel = 3'd6;
    tick();
    chk("rd_during_update_old", rd32, model[0][6]);
    model_add(4'hF);
    tick();
    chk("rd_after_update_new", rd32, model[0][6]);
    rd_req = 1'b0;

    // read and clear together return the pre-clear value
    rd_req = 1'b1;
    rd_sel = 3'd6;
    clear  = 1'b1;
    tick();
    clear  = 1'b0;
    rd_req = 1'b0;
    chk("rd_with_clear_old", rd32, model[0][6]);
    model_clear();
    read_one(6);
    rd_req = 1'b0;

    // clear collides with beat A's counter update: A is lost, B counts from zero
    d32 = '{32'h6480_0000, 32'h6480_0000, 32'h6480_0000, 32'h6480_0000};
    drive_beat(1'b1, 4'hF);
    d32 = '{32'h0080_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000};
    d16 = '{32'h0400, 32'h0000, 32'h7C00, 32'h7C00};
    clear = 1'b1;
    drive_beat(1'b1, 4'b0011);
    clear = 1'b0;
    model_clear();
    model_add(4'b0011);
    tick();
    read_all();
    chk("clear_maxexp_restart", rd32, 1);
    read_one(6);
    chk("clear_total_restart", rd32, 2);

    // saturation of the 8-bit counters
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    for (int n = 0; n < 66; n++) begin
      for (int i = 0; i < 4; i++) begin
        d32[i] = make_word(2, 8, 23);
        d16[i] = make_word(2, 5, 10);
      end
      drive_beat(1'b1, 4'hF);
      model_add(4'hF);
    end
    tick();
    read_one(2);
    chk("sat_normal8", rd8, 255);
    chk("normal32_264", rd32, 264);
    read_one(6);
    chk("sat_total8", rd8, 255);
    rd_req = 1'b0;
    tick();
    read_all();

    // reset mid-stream discards both pipeline stages
    for (int i = 0; i < 4; i++) begin
      d32[i] = make_word($urandom_range(0, 4), 8, 23);
      d16[i] = make_word($urandom_range(0, 4), 5, 10);
    end
    drive_beat(1'b1, 4'hF);
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_cls_valid", cv32, 0);
    chk("midrst_cls_code", cc32, 12'hFFF);
    chk("midrst_rd_valid", rv32, 0);
    chk("midrst_rd_data", rd32, 0);
    model_clear();
    tick();
    read_all();
    read_one(6);
    chk("midrst_total_zero", rd32, 0);
    rd_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
